// File: rtl/vga_fb_render.sv
// vga_fb_render: indexed-colour framebuffer with a round-robin rectangle fill / clear engine and 2-stage RGB444 scan-out.
// Optional macro VGA_FB_PAL_WR_EN adds a run-time writable palette (pal_we/pal_addr/pal_data).
module vga_fb_render #(
  parameter int FB_W   = 240,
  parameter int FB_H   = 320,
  parameter int IDX_W  = 4,
  parameter int N_CH   = 4,
  parameter int BG_IDX = 7
) (
  input  logic                    vga_clk,
  input  logic                    sys_rst_n,
  input  logic [9:0]              pix_x,
  input  logic [9:0]              pix_y,
  input  logic [N_CH-1:0]         rect_valid,
  output logic [N_CH-1:0]         rect_ready,
  input  logic [N_CH*10-1:0]      rect_x0,
  input  logic [N_CH*10-1:0]      rect_x1,
  input  logic [N_CH*10-1:0]      rect_y0,
  input  logic [N_CH*10-1:0]      rect_y1,
  input  logic [N_CH*IDX_W-1:0]   rect_color,
  input  logic                    clr_req,
  output logic                    busy,
  output logic [11:0]             pix_data
`ifdef VGA_FB_PAL_WR_EN
  ,
  input  logic                    pal_we,
  input  logic [IDX_W-1:0]        pal_addr,
  input  logic [11:0]             pal_data
`endif
);
  localparam int N  = FB_W * FB_H;
  localparam int AW = $clog2(N);
  localparam int CW = N_CH > 1 ? $clog2(N_CH) : 1;
  localparam logic [9:0]    XW = 10'(FB_W);
  localparam logic [9:0]    YH = 10'(FB_H);
  localparam logic [AW-1:0] WA = AW'(FB_W);

  typedef enum logic [1:0] {IDLE, FILL, CLEAR} state_t;
  state_t state, state_nx;

  logic [IDX_W-1:0] fb [N] = '{default: IDX_W'(BG_IDX)};

  logic [CW-1:0]    ptr, gnt, cand;
  logic             gnt_ok, accept, empty, we, rin, in_rng;
  logic [9:0]       sx0, sx1, sy0, sy1, x0, x1, y1, cx, cy;
  logic [IDX_W-1:0] col, wd, ri;
  logic [AW-1:0]    ca, wa, ra;
  logic [11:0]      pal_rd;

  function automatic logic [11:0] pal_def(input int i);
    case (i)
      0: return 12'hf00;
      1: return 12'hf80;
      2: return 12'hff0;
      3: return 12'h0f0;
      4: return 12'h0ff;
      5: return 12'h00f;
      6: return 12'hf0f;
      8: return 12'hfff;
      9: return 12'h444;
      default: return 12'h000;
    endcase
  endfunction

  // Iterate from the far end so the closest valid channel after ptr wins.
  always_comb begin
    gnt_ok = 1'b0;
    gnt = '0;
    cand = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      cand = CW'((int'(ptr) + i) % N_CH);
      if (rect_valid[cand]) begin
        gnt_ok = 1'b1;
        gnt = cand;
      end
    end
  end

  assign sx0 = rect_x0[int'(gnt)*10 +: 10];
  assign sx1 = rect_x1[int'(gnt)*10 +: 10];
  assign sy0 = rect_y0[int'(gnt)*10 +: 10];
  assign sy1 = rect_y1[int'(gnt)*10 +: 10];
  assign accept = state == IDLE && !clr_req && gnt_ok;
  assign rect_ready = (sys_rst_n && accept) ? N_CH'(1) << gnt : '0;
  assign busy = state != IDLE;
  assign empty = x0 >= x1 || cy >= y1;

  always_comb begin
    state_nx = state;
    we = 1'b0;
    wa = ca;
    wd = IDX_W'(BG_IDX);
    case (state)
      IDLE: state_nx = clr_req ? CLEAR : gnt_ok ? FILL : IDLE;
      FILL: begin
        we = !empty;
        wa = AW'(cy) * WA + AW'(cx);
        wd = col;
        state_nx = empty ? IDLE : FILL;
      end
      CLEAR: begin
        we = 1'b1;
        state_nx = ca == AW'(N - 1) ? IDLE : CLEAR;
      end
      default: state_nx = IDLE;
    endcase
  end

  // The fill walks past its last row, so the final FILL cycle finds the rectangle empty and exits.
  always_ff @(posedge vga_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state <= IDLE;
      ptr <= '0;
      x0 <= '0;
      x1 <= '0;
      y1 <= '0;
      cx <= '0;
      cy <= '0;
      col <= '0;
      ca <= '0;
    end else begin
      state <= state_nx;
      ca <= state == CLEAR ? ca + 1'b1 : '0;
      if (accept) begin
        ptr <= gnt == CW'(N_CH - 1) ? '0 : gnt + 1'b1;
        x0 <= sx0;
        cx <= sx0;
        cy <= sy0;
        x1 <= sx1 > XW ? XW : sx1;
        y1 <= sy1 > YH ? YH : sy1;
        col <= rect_color[int'(gnt)*IDX_W +: IDX_W];
      end
      if (state == FILL && !empty) begin
        cx <= cx == x1 - 1'b1 ? x0 : cx + 1'b1;
        if (cx == x1 - 1'b1) cy <= cy + 1'b1;
      end
    end

  always_ff @(posedge vga_clk)
    if (we) fb[wa] <= wd;

  assign in_rng = pix_x < XW && pix_y < YH;
  assign ri = fb[ra];

`ifdef VGA_FB_PAL_WR_EN
  logic [11:0] pal [2**IDX_W];
  always_ff @(posedge vga_clk or negedge sys_rst_n)
    if (!sys_rst_n) for (int i = 0; i < 2**IDX_W; i++) pal[i] <= pal_def(i);
    else if (pal_we) pal[pal_addr] <= pal_data;
  assign pal_rd = pal[ri];
`else
  assign pal_rd = pal_def(int'(ri));
`endif

  // Stage-2 reads the RAM with the pre-write contents, so a same-cycle write returns old data.
  always_ff @(posedge vga_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      ra <= '0;
      rin <= 1'b0;
      pix_data <= 12'h000;
    end else begin
      ra <= in_rng ? AW'(pix_y) * WA + AW'(pix_x) : '0;
      rin <= in_rng;
      pix_data <= rin ? pal_rd : 12'h000;
    end
endmodule

// File: tb/tb_vga_fb_render.sv
// tb_vga_fb_render: scoreboard bench; scans push expected pixels into a queue, a monitor pops them two cycles later.
module tb_vga_fb_render;
  localparam int NC = 4;
  logic              vga_clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic [9:0]        pix_x = '0, pix_y = '0;
  logic [NC-1:0]     rect_valid = '0;
  logic [NC-1:0]     rect_ready;
  logic [NC*10-1:0]  rect_x0 = '0, rect_x1 = '0, rect_y0 = '0, rect_y1 = '0;
  logic [NC*4-1:0]   rect_color = '0;
  logic              clr_req = 1'b0;
  logic              busy;
  logic [11:0]       pix_data;
`ifdef VGA_FB_PAL_WR_EN
  logic              pal_we = 1'b0;
  logic [3:0]        pal_addr = '0;
  logic [11:0]       pal_data = '0;
`endif

  int n_cmp = 0, n_bad = 0;
  typedef struct {int x; int y; logic [11:0] e;} exp_t;
  exp_t q[$];
  logic scan_v = 1'b0, sv1 = 1'b0, sv2 = 1'b0;

  always #5 vga_clk = ~vga_clk;

  vga_fb_render dut (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .pix_x(pix_x), .pix_y(pix_y),
    .rect_valid(rect_valid), .rect_ready(rect_ready),
    .rect_x0(rect_x0), .rect_x1(rect_x1), .rect_y0(rect_y0), .rect_y1(rect_y1),
    .rect_color(rect_color), .clr_req(clr_req), .busy(busy), .pix_data(pix_data)
`ifdef VGA_FB_PAL_WR_EN
    , .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data)
`endif
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always_ff @(posedge vga_clk) begin
    sv1 <= scan_v;
    sv2 <= sv1;
  end

  always @(negedge vga_clk)
    if (sv2) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pix: output with no expected entry, got %h", pix_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        n_cmp++;
        if (pix_data !== e.e) begin
          n_bad++;
          $display("FAIL pix(%0d,%0d): got %h expected %h", e.x, e.y, pix_data, e.e);
        end
      end
    end

  task automatic scan(input int x, input int y, input logic [11:0] e);
    pix_x = 10'(x);
    pix_y = 10'(y);
    scan_v = 1'b1;
    q.push_back('{x, y, e});
    @(posedge vga_clk);
    #1 scan_v = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(posedge vga_clk);
    #1;
  endtask

  task automatic set_rect(input int ch, input int x0, input int y0, input int x1, input int y1, input int c);
    rect_x0[ch*10 +: 10] = 10'(x0);
    rect_y0[ch*10 +: 10] = 10'(y0);
    rect_x1[ch*10 +: 10] = 10'(x1);
    rect_y1[ch*10 +: 10] = 10'(y1);
    rect_color[ch*4 +: 4] = 4'(c);
  endtask

  task automatic busy_len(output int n);
    n = 0;
    for (int i = 0; i < 100000; i++) begin
      @(negedge vga_clk);
      if (!busy) break;
      n++;
    end
  endtask

  // Expects a grant in the current or a later IDLE cycle, then drops that channel's valid after the accepting edge.
  task automatic grant(input string nm, input logic [3:0] exp, input int ch, input int exp_busy);
    int n;
    for (int i = 0; i < 100000; i++) begin
      if (rect_ready != 0) break;
      @(negedge vga_clk);
    end
    chk({nm, " ready"}, int'(rect_ready), int'(exp));
    @(posedge vga_clk);
    #1 rect_valid[ch] = 1'b0;
    busy_len(n);
    chk({nm, " busy cycles"}, n, exp_busy);
  endtask

  task automatic do_rect(input string nm, input int ch, input int x0, input int y0, input int x1,
                         input int y1, input int c, input int exp_busy);
    set_rect(ch, x0, y0, x1, y1, c);
    rect_valid[ch] = 1'b1;
    #1;
    grant(nm, 4'(1 << ch), ch, exp_busy);
  endtask

  initial begin
    int n;
    rect_valid = 4'hf;
    repeat (3) @(negedge vga_clk);
    chk("reset busy", int'(busy), 0);
    chk("reset ready", int'(rect_ready), 0);
    chk("reset pix", int'(pix_data), 0);
    rect_valid = '0;
    @(posedge vga_clk);
    #1 sys_rst_n = 1'b1;
    scan(0, 0, 12'h000);
    scan(300, 10, 12'h000);
    scan(1023, 1023, 12'h000);
    drain();
    set_rect(0, 0, 0, 0, 0, 1);
    set_rect(2, 5, 5, 5, 5, 1);
    rect_valid = 4'b0101;
    #1;
    grant("arb1 ch0", 4'b0001, 0, 1);
    grant("arb1 ch2", 4'b0100, 2, 1);
    rect_valid = 4'b0101;
    #1;
    grant("arb2 ch0", 4'b0001, 0, 1);
    grant("arb2 ch2", 4'b0100, 2, 1);
    do_rect("rect ch1", 1, 10, 20, 14, 22, 0, 9);
    scan(13, 21, 12'hf00);
    scan(14, 21, 12'h000);
    scan(10, 20, 12'hf00);
    scan(9, 20, 12'h000);
    scan(13, 22, 12'h000);
    scan(10, 19, 12'h000);
    do_rect("clip ch3", 3, 230, 310, 500, 400, 3, 101);
    do_rect("empty ch0", 0, 50, 50, 50, 60, 5, 1);
    scan(50, 50, 12'h000);
    scan(230, 310, 12'h0f0);
    scan(229, 315, 12'h000);
    scan(239, 309, 12'h000);
    scan(239, 319, 12'h0f0);
    drain();
    set_rect(2, 0, 100, 240, 110, 2);
    rect_valid[2] = 1'b1;
    #1;
    for (int i = 0; i < 1000; i++) begin
      if (rect_ready != 0) break;
      @(negedge vga_clk);
    end
    chk("abort ready", int'(rect_ready), 4);
    @(posedge vga_clk);
    #1 rect_valid[2] = 1'b0;
    repeat (10) @(posedge vga_clk);
    #1 sys_rst_n = 1'b0;
    #1;
    chk("abort busy", int'(busy), 0);
    chk("abort pix", int'(pix_data), 0);
    repeat (2) @(posedge vga_clk);
    #1 sys_rst_n = 1'b1;
    scan(0, 100, 12'hff0);
    scan(9, 100, 12'hff0);
    scan(10, 100, 12'h000);
    scan(200, 105, 12'h000);
    drain();
    set_rect(0, 0, 0, 2, 1, 8);
    clr_req = 1'b1;
    rect_valid[0] = 1'b1;
    #1;
    chk("clr prio ready", int'(rect_ready), 0);
    @(posedge vga_clk);
    #1 clr_req = 1'b0;
    n = 0;
    for (int i = 0; i < 100000; i++) begin
      @(negedge vga_clk);
      if (rect_ready != 0) break;
      if (busy) n++;
    end
    chk("clear cycles", n, 76800);
    grant("post clr ch0", 4'b0001, 0, 3);
    scan(0, 0, 12'hfff);
    scan(1, 0, 12'hfff);
    scan(2, 0, 12'h000);
    scan(0, 1, 12'h000);
    scan(13, 21, 12'h000);
    scan(239, 319, 12'h000);
    scan(0, 100, 12'h000);
    drain();
`ifdef VGA_FB_PAL_WR_EN
    pal_we = 1'b1;
    pal_addr = 4'd7;
    pal_data = 12'habc;
    @(posedge vga_clk);
    #1 pal_we = 1'b0;
    scan(200, 200, 12'habc);
    drain();
    sys_rst_n = 1'b0;
    repeat (2) @(posedge vga_clk);
    #1 sys_rst_n = 1'b1;
    scan(200, 200, 12'h000);
    drain();
`endif
    chk("queue empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vga_fb_render.md
VGA_FB_RENDER -- requirements
Module: vga_fb_render

Interface
REQ-001 The block SHALL have parameter FB_W, default 240, meaning framebuffer width in pixels.
REQ-002 The block SHALL have parameter FB_H, default 320, meaning framebuffer height in pixels.
REQ-003 The block SHALL have parameter IDX_W, default 4, meaning colour-index width; the palette holds 2^IDX_W entries.
REQ-004 The block SHALL have parameter N_CH, default 4, meaning number of rectangle-request channels.
REQ-005 The block SHALL have parameter BG_IDX, default 7, meaning background/clear colour index.
REQ-006 The block SHALL have port vga_clk, input, 1 bit: pixel clock.
REQ-007 The block SHALL have port sys_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port pix_x, input, 10 bits: scan X coordinate.
REQ-009 The block SHALL have port pix_y, input, 10 bits: scan Y coordinate.
REQ-010 The block SHALL have port rect_valid, input, N_CH bits: per-channel request valid.
REQ-011 The block SHALL have port rect_ready, output, N_CH bits: per-channel accept.
REQ-012 The block SHALL have ports rect_x0, rect_x1, rect_y0 and rect_y1, inputs, N_CH*10 bits each: packed per-channel rectangle bounds, channel k in bits [10k+9:10k].
REQ-013 The block SHALL have port rect_color, input, N_CH*IDX_W bits: packed per-channel fill index.
REQ-014 The block SHALL have port clr_req, input, 1 bit: level request to clear the whole framebuffer.
REQ-015 The block SHALL have port busy, output, 1 bit: engine not idle.
REQ-016 The block SHALL have port pix_data, output, 12 bits: RGB444 pixel.

Function
REQ-017 The block SHALL hold a framebuffer of FB_W*FB_H IDX_W-bit entries at address y*FB_W+x, initialised to BG_IDX at configuration.
REQ-018 The write engine SHALL be an FSM with states IDLE, FILL and CLEAR; busy SHALL be 1 in any state other than IDLE.
REQ-019 In IDLE, clr_req=1 SHALL have priority: next state is CLEAR, and no rect_ready is asserted that cycle.
REQ-020 In IDLE with no clr_req, the block SHALL grant one valid channel round-robin, starting at the channel after the last granted one (channel 0 after reset), assert that channel's rect_ready for exactly one cycle, latch its bounds and colour, and go to FILL.
REQ-021 rect_ready SHALL be 0 in every state other than IDLE, and at most one bit of rect_ready SHALL be set in any cycle.
REQ-022 FILL SHALL write one pixel per cycle in raster order over x0<=x<x1 and y0<=y<y1 (end-exclusive bounds).
REQ-023 The first FILL write SHALL occur in the cycle after acceptance.
REQ-024 FILL SHALL return to IDLE in the cycle after the last write.
REQ-025 Before filling, x1 SHALL be clipped to FB_W and y1 to FB_H.
REQ-026 An empty or fully clipped rectangle (x0>=x1 or y0>=y1 after clipping) SHALL spend one cycle in FILL with no writes.
REQ-027 CLEAR SHALL write BG_IDX to addresses 0..FB_W*FB_H-1, one per cycle, then return to IDLE; clr_req is ignored while in CLEAR.
REQ-028 The read path SHALL be a 2-stage pipeline: stage 1 registers the address and an in-range flag (pix_x<FB_W and pix_y<FB_H); stage 2 reads the RAM and performs the palette lookup into the pix_data register.
REQ-029 pix_data SHALL correspond to the pix_x/pix_y presented 2 cycles earlier.
REQ-030 An out-of-range coordinate (including 1023) SHALL output 12'h000.
REQ-031 When a write and a read hit the same address in the same cycle, the read SHALL return the old data.
REQ-032 The default palette SHALL be: 0 f00, 1 f80, 2 ff0, 3 0f0, 4 0ff, 5 00f, 6 f0f, 7 000, 8 fff, 9 444; all other entries 000.

Reset
REQ-033 Asserting sys_rst_n low SHALL force the FSM to IDLE and clear pix_data, rect_ready, busy, the round-robin pointer and the pipeline registers.
REQ-034 Reset SHALL NOT clear framebuffer contents.
REQ-035 Reset mid-FILL or mid-CLEAR SHALL abort the operation; pixels already written SHALL remain.

Configuration
REQ-036 With macro VGA_FB_PAL_WR_EN defined, the block SHALL add inputs pal_we (1 bit), pal_addr (IDX_W bits) and pal_data (12 bits).
REQ-037 With VGA_FB_PAL_WR_EN defined, the palette SHALL be registers reset to the REQ-032 defaults, and a write SHALL affect every stage-2 lookup from the next cycle onward.
REQ-038 Without VGA_FB_PAL_WR_EN, the pal_* ports SHALL be absent and the palette SHALL be a fixed table.

Verification
REQ-039 Reset, then scan (0,0) with no writes -> pix_data=000 (BG_IDX 7) two cycles later; scan (300,10) -> 000.
REQ-040 Channel 1 requests rect (10,20)-(14,22) with colour 0 -> rect_ready[1] pulses once, busy high for 9 cycles, 8 writes; scanning (13,21) -> f00, (14,21) -> 000.
REQ-041 Channels 0 and 2 valid simultaneously after reset -> channel 0 is granted first and channel 2 next; a repeat of both -> channel 2 is not granted twice in a row.
REQ-042 clr_req held together with rect_valid[0] in IDLE -> CLEAR runs for 76800 cycles first, then channel 0 is granted.
REQ-043 Rect (230,310)-(500,400) with colour 3 -> clipped fill of 10x10 pixels; (239,319) -> 0f0; rect (50,50)-(50,60) -> 0 writes, 1 busy cycle.
REQ-044 With VGA_FB_PAL_WR_EN defined, write pal[7]=abc, then scan a background pixel -> abc; assert reset -> reads 000 again.
